// File: rtl/zion_riscv_isa_lib_add_sub_arbiter.sv
// Shared add/sub datapath with a round-robin arbiter across NUM_REQ requesters.
// One request is granted per cycle. Its add/sub/.W result and less-than flag are
// captured in a single output register with valid/ready backpressure.
`timescale 1ns/1ps

module zion_riscv_isa_lib_add_sub_arbiter #(
  parameter  int RV64      = 0,
  parameter  int NUM_REQ   = 4,
  localparam int CPU_WIDTH = 32 * (RV64 + 1),
  localparam int OP_W      = RV64 + 2,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  iReqVld,
  output logic [NUM_REQ-1:0]                  oReqRdy,
  input  logic [NUM_REQ-1:0][OP_W-1:0]        iReqOp,
  input  logic [NUM_REQ-1:0]                  iReqUns,
  input  logic [NUM_REQ-1:0][CPU_WIDTH-1:0]   iReqS1,
  input  logic [NUM_REQ-1:0][CPU_WIDTH-1:0]   iReqS2,
  output logic                                oRspVld,
  input  logic                                iRspRdy,
  output logic [ID_W-1:0]                     oRspId,
  output logic [CPU_WIDTH-1:0]                oRspRslt,
  output logic                                oRspLt,
  output logic                                oRspErr
);

  // Round-robin pointer and output register state.
  logic [ID_W-1:0]      ptr_q,      ptr_d;
  logic                 rsp_vld_q,  rsp_vld_d;
  logic [ID_W-1:0]      rsp_id_q,   rsp_id_d;
  logic [CPU_WIDTH-1:0] rsp_rslt_q, rsp_rslt_d;
  logic                 rsp_lt_q,   rsp_lt_d;
  logic                 rsp_err_q,  rsp_err_d;

  // Arbitration.
  logic                 slot_free;
  logic                 gnt_found;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W:0]        cand;
  logic                 xfer;

  // Datapath for the granted request.
  logic [OP_W-1:0]      sel_op;
  logic                 sel_uns;
  logic [CPU_WIDTH-1:0] sel_s1;
  logic [CPU_WIDTH-1:0] sel_s2;
  logic                 sel_add;
  logic                 sel_sub;
  logic [CPU_WIDTH-1:0] s2_opnd;
  logic [CPU_WIDTH-1:0] sum;
  logic [CPU_WIDTH-1:0] raw_rslt;
  logic                 s1_msb;
  logic                 s2_msb;

  // The slot can take a new result when empty or when being drained this cycle.
  assign slot_free = !rsp_vld_q || iRspRdy;

  // Pick the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  // NOTE: every signal assigned in an always_comb gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W + 1)'(i);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      if (!gnt_found && iReqVld[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand[ID_W-1:0];
      end
    end
  end

  assign xfer = slot_free && gnt_found && !rst;

  // Drive a one-hot accept for the granted requester only when it transfers.
  always_comb begin
    oReqRdy = '0;
    if (xfer) begin
      oReqRdy[gnt_id] = 1'b1;
    end
  end

  assign sel_op  = iReqOp[gnt_id];
  assign sel_uns = iReqUns[gnt_id];
  assign sel_s1  = iReqS1[gnt_id];
  assign sel_s2  = iReqS2[gnt_id];
  assign sel_add = sel_op[0];
  assign sel_sub = sel_op[1];

  // Single adder: subtraction is s1 + ~s2 + 1; neither or both ops give zero.
  assign s2_opnd  = sel_sub ? ~sel_s2 : sel_s2;
  assign sum      = sel_s1 + s2_opnd + CPU_WIDTH'(sel_sub);
  assign raw_rslt = (sel_add ^ sel_sub) ? sum : '0;

  // .W narrows to the low word and sign-extends; only exists on the 64-bit datapath.
  if (RV64 != 0) begin : g_rv64
    assign rsp_rslt_d = sel_op[OP_W-1] ? {{32{raw_rslt[31]}}, raw_rslt[31:0]} : raw_rslt;
  end else begin : g_rv32
    assign rsp_rslt_d = raw_rslt;
  end

  // Less-than always uses the full-width msb. When the msbs match, the msb of
  // s1 - s2 is the borrow out of the lower bits, i.e. s1[low] < s2[low].
  assign s1_msb = sel_s1[CPU_WIDTH-1];
  assign s2_msb = sel_s2[CPU_WIDTH-1];
  assign rsp_lt_d  = (s1_msb != s2_msb) ? (sel_uns ? s2_msb : s1_msb)
                                        : (sel_s1[CPU_WIDTH-2:0] < sel_s2[CPU_WIDTH-2:0]);
  assign rsp_err_d = sel_add && sel_sub;
  assign rsp_id_d  = gnt_id;

  // Next valid flag and pointer: load on transfer, clear on drain, else hold.
  always_comb begin
    rsp_vld_d = rsp_vld_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      rsp_vld_d = 1'b1;
      ptr_d     = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (iRspRdy) begin
      rsp_vld_d = 1'b0;
    end
  end

  // Register the response on a transfer; synchronous reset clears everything.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order. The result fields are reset
  // too because their reset value is architecturally visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_rslt_q <= '0;
      rsp_lt_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rsp_vld_q <= rsp_vld_d;
      if (xfer) begin
        rsp_id_q   <= rsp_id_d;
        rsp_rslt_q <= rsp_rslt_d;
        rsp_lt_q   <= rsp_lt_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

  assign oRspVld  = rsp_vld_q;
  assign oRspId   = rsp_id_q;
  assign oRspRslt = rsp_rslt_q;
  assign oRspLt   = rsp_lt_q;
  assign oRspErr  = rsp_err_q;

  // Protocol properties.
  a_rdy_onehot: assert property (@(posedge clk) $onehot0(oReqRdy));
  a_rdy_in_rst: assert property (@(posedge clk) rst |-> (oReqRdy == '0));
  a_rsp_stable: assert property (@(posedge clk)
    (oRspVld && !iRspRdy && !rst) |=> (oRspVld && $stable(oRspId) && $stable(oRspRslt)
                                       && $stable(oRspLt) && $stable(oRspErr)));

endmodule
